// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronizers, clock glitch filter, 11-bit frame decoder
// with parity/stop checking and timeout, feeding a first-word-fall-through byte FIFO.
module ps2_rx_fifo #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000,
   parameter int FIFO_DEPTH     = 8
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset_n,
   input  logic                          ps2_clk,
   input  logic                          ps2_data,
   output logic [7:0]                    rd_data,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overflow,
   input  logic                          clr_err,
   output logic [1:0]                    fsm_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [AW:0]   DEPTH_V = (AW + 1)'(FIFO_DEPTH);
   localparam logic [FW-1:0] FL_M1   = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_V    = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

   state_t          state, state_n;
   logic [1:0]      sync_clk_q, sync_data_q;
   logic            sync_clk, sync_data;
   logic            filt_clk, filt_prev, fall;
   logic [FW-1:0]   filt_cnt;
   logic [2:0]      bitcnt;
   logic [7:0]      shreg;
   logic            par_bit;
   logic [TW-1:0]   tcnt;
   logic            timeout, stop_fall, frame_ok, push, pop, do_push;
   logic            pe_set, fe_set, ov_set;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            full, empty;

   assign sync_clk  = sync_clk_q[1];
   assign sync_data = sync_data_q[1];
   assign fall      = filt_prev & ~filt_clk;

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         sync_clk_q  <= 2'b11;
         sync_data_q <= 2'b11;
         filt_clk    <= 1'b1;
         filt_prev   <= 1'b1;
         filt_cnt    <= '0;
      end else begin
         sync_clk_q  <= {sync_clk_q[0], ps2_clk};
         sync_data_q <= {sync_data_q[0], ps2_data};
         filt_prev   <= filt_clk;
         // The level only follows the synchronized pin after FILTER_LEN differing cycles in a row.
         if (sync_clk != filt_clk) begin
            if (filt_cnt == FL_M1) begin
               filt_clk <= sync_clk;
               filt_cnt <= '0;
            end else begin
               filt_cnt <= filt_cnt + 1'b1;
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) state <= IDLE;
      else                state <= state_n;
   end

   always_comb begin
      state_n = state;
      timeout = 1'b0;
      case (state)
         IDLE:    if (fall && !sync_data)      state_n = DATA;
         DATA:    if (fall && bitcnt == 3'd7)  state_n = PARITY;
         PARITY:  if (fall)                    state_n = STOP;
         STOP:    if (fall)                    state_n = IDLE;
         default:                              state_n = IDLE;
      endcase
      if (state != IDLE && !fall && tcnt == TO_V) begin
         timeout = 1'b1;
         state_n = IDLE;
      end
   end

   assign fsm_state = state;
   assign stop_fall = (state == STOP) && fall;
   assign frame_ok  = ^{shreg, par_bit};
   assign push      = stop_fall && sync_data && frame_ok;
   assign pe_set    = stop_fall && sync_data && !frame_ok;
   assign fe_set    = (stop_fall && !sync_data) || timeout;

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         bitcnt  <= 3'd0;
         shreg   <= 8'h00;
         par_bit <= 1'b0;
         tcnt    <= '0;
      end else begin
         tcnt <= (state == IDLE || fall || timeout) ? '0 : tcnt + 1'b1;
         if (state == IDLE) bitcnt <= 3'd0;
         if (fall && state == DATA) begin
            shreg  <= {sync_data, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
         end
         if (fall && state == PARITY) par_bit <= sync_data;
      end
   end

   assign full     = (count == DEPTH_V);
   assign empty    = (count == '0);
   assign rd_valid = !empty;
   assign pop      = rd_valid && rd_ready;
   // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
   assign do_push  = push && (!full || pop);
   assign ov_set   = push && full && !pop;
   assign rd_data  = empty ? 8'h00 : mem[rd_ptr];
   assign fifo_count = count;

   always_ff @(posedge clk_clk) begin
      if (do_push) mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !pop)      count <= count + 1'b1;
         else if (pop && !do_push) count <= count - 1'b1;
         parity_err <= pe_set | (parity_err & ~clr_err);
         frame_err  <= fe_set | (frame_err  & ~clr_err);
         overflow   <= ov_set | (overflow   & ~clr_err);
      end
   end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives PS/2 frames on the raw pins and checks the read port,
// occupancy and sticky error flags against hand-computed values.
module tb_ps2_rx_fifo;

   localparam int FL   = 4;
   localparam int TO   = 300;
   localparam int HALF = 30;

   logic       clk_clk = 1'b0;
   logic       reset_reset_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rd_ready = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic [3:0] fifo_count;
   logic       parity_err, frame_err, overflow;
   logic [1:0] fsm_state;

   int n_cmp = 0;
   int n_err = 0;

   ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(8)) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .fifo_count(fifo_count),
      .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow), .clr_err(clr_err),
      .fsm_state(fsm_state)
   );

   always #5 clk_clk = ~clk_clk;

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk_clk);
   endtask

   // One bit cell: data set while clock high, then clock low for HALF cycles.
   task automatic ps2_bit(input logic b, input bit glitch);
      ps2_data = b;
      if (glitch) begin
         wait_cycles(10);
         ps2_clk = 1'b0;
         wait_cycles(FL - 1);
         ps2_clk = 1'b1;
         wait_cycles(HALF - 10 - (FL - 1));
      end else begin
         wait_cycles(HALF);
      end
      ps2_clk = 1'b0;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop, input int glitch_bit);
      logic par;
      par = bad_par ? ^d : ~^d;
      ps2_bit(1'b0, glitch_bit == 0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i], glitch_bit == i + 1);
      ps2_bit(par, 1'b0);
      ps2_bit(stop, 1'b0);
      ps2_data = 1'b1;
      wait_cycles(HALF);
   endtask

   task automatic send_partial(input logic [7:0] d, input int nbits);
      ps2_bit(1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) ps2_bit(d[i], 1'b0);
      ps2_data = 1'b1;
   endtask

   task automatic pop_one();
      rd_ready = 1'b1;
      wait_cycles(1);
      rd_ready = 1'b0;
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      wait_cycles(1);
      clr_err = 1'b0;
   endtask

   task automatic test_reset();
      reset_reset_n = 1'b0;
      wait_cycles(5);
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
      n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", rd_data); end
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      n_cmp++; if ({parity_err, frame_err, overflow} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {parity_err, frame_err, overflow}); end
      n_cmp++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
      reset_reset_n = 1'b1;
      wait_cycles(5);
   endtask

   task automatic test_good_frame();
      send_frame(8'h1C, 1'b0, 1'b1, -1);
      n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL good_valid: got %b want 1", rd_valid); end
      n_cmp++; if (rd_data !== 8'h1C) begin n_err++; $display("FAIL good_data: got %h want 1c", rd_data); end
      n_cmp++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL good_count: got %0d want 1", fifo_count); end
      n_cmp++; if ({parity_err, frame_err, overflow} !== 3'b000) begin n_err++; $display("FAIL good_flags: got %b want 000", {parity_err, frame_err, overflow}); end
      pop_one();
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL good_pop_valid: got %b want 0", rd_valid); end
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL good_pop_count: got %0d want 0", fifo_count); end
      pop_one();
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL empty_pop_count: got %0d want 0", fifo_count); end
   endtask

   task automatic test_parity();
      send_frame(8'h1C, 1'b1, 1'b1, -1);
      n_cmp++; if (parity_err !== 1'b1) begin n_err++; $display("FAIL par_err: got %b want 1", parity_err); end
      n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL par_frame: got %b want 0", frame_err); end
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL par_count: got %0d want 0", fifo_count); end
      pulse_clr();
      n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL par_clr: got %b want 0", parity_err); end
   endtask

   task automatic test_stop_bit();
      send_frame(8'hF0, 1'b0, 1'b0, -1);
      n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL stop_err: got %b want 1", frame_err); end
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL stop_count: got %0d want 0", fifo_count); end
      n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL stop_par: got %b want 0", parity_err); end
      send_frame(8'hF0, 1'b0, 1'b1, -1);
      n_cmp++; if (rd_data !== 8'hF0) begin n_err++; $display("FAIL stop_good_data: got %h want f0", rd_data); end
      n_cmp++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL stop_good_count: got %0d want 1", fifo_count); end
      pop_one();
      pulse_clr();
      n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL stop_clr: got %b want 0", frame_err); end
   endtask

   task automatic test_timeout();
      send_partial(8'h15, 5);
      n_cmp++; if (fsm_state !== 2'd1) begin n_err++; $display("FAIL to_midframe_state: got %0d want 1", fsm_state); end
      wait_cycles(TO + 20);
      n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", frame_err); end
      n_cmp++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL to_state: got %0d want 0", fsm_state); end
      n_cmp++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL to_count: got %0d want 0", fifo_count); end
      pulse_clr();
      send_frame(8'h5A, 1'b0, 1'b1, -1);
      n_cmp++; if (rd_data !== 8'h5A) begin n_err++; $display("FAIL to_next_data: got %h want 5a", rd_data); end
      n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL to_next_flag: got %b want 0", frame_err); end
      pop_one();
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, -1);
      n_cmp++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL ovf_count: got %0d want 8", fifo_count); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      for (int i = 1; i <= 8; i++) begin
         n_cmp++; if (rd_data !== 8'(i)) begin n_err++; $display("FAIL ovf_drain_%0d: got %h want %h", i, rd_data, 8'(i)); end
         pop_one();
      end
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b want 0", rd_valid); end
      pulse_clr();
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", overflow); end
   endtask

   task automatic test_glitch();
      ps2_data = 1'b0;
      wait_cycles(5);
      ps2_clk = 1'b0;
      wait_cycles(FL - 1);
      ps2_clk = 1'b1;
      wait_cycles(20);
      n_cmp++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL glitch_idle_state: got %0d want 0", fsm_state); end
      ps2_data = 1'b1;
      wait_cycles(5);
      send_frame(8'hA5, 1'b0, 1'b1, 4);
      n_cmp++; if (rd_data !== 8'hA5) begin n_err++; $display("FAIL glitch_data: got %h want a5", rd_data); end
      n_cmp++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL glitch_count: got %0d want 1", fifo_count); end
      n_cmp++; if ({parity_err, frame_err} !== 2'b00) begin n_err++; $display("FAIL glitch_flags: got %b want 00", {parity_err, frame_err}); end
      pop_one();
   endtask

   task automatic test_reset_midframe();
      send_partial(8'hFF, 4);
      reset_reset_n = 1'b0;
      wait_cycles(3);
      reset_reset_n = 1'b1;
      wait_cycles(5);
      n_cmp++; if (fsm_state !== 2'd0) begin n_err++; $display("FAIL rst_mid_state: got %0d want 0", fsm_state); end
      send_frame(8'h3C, 1'b0, 1'b1, -1);
      n_cmp++; if (rd_data !== 8'h3C) begin n_err++; $display("FAIL rst_mid_data: got %h want 3c", rd_data); end
      n_cmp++; if (fifo_count !== 4'd1) begin n_err++; $display("FAIL rst_mid_count: got %0d want 1", fifo_count); end
      n_cmp++; if ({parity_err, frame_err, overflow} !== 3'b000) begin n_err++; $display("FAIL rst_mid_flags: got %b want 000", {parity_err, frame_err, overflow}); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_parity();
      test_stop_bit();
      test_timeout();
      test_overflow();
      test_glitch();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
